// File: rtl/l1_cache_pkg.sv
// Shared geometry and types for the L1 tag path: address split, tag/index types
// and the tag controller state encoding.
package l1_cache_pkg;

   localparam int TAG_W    = 23;
   localparam int IDX_W    = 5;
   localparam int OFF_W    = 4;
   localparam int NUM_SETS = 1 << IDX_W;

   typedef logic [TAG_W-1:0] tag_t;
   typedef logic [IDX_W-1:0] idx_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOOKUP    = 2'd1,
      MISS_WAIT = 2'd2,
      FILL      = 2'd3
   } tag_state_e;

endpackage

// File: rtl/l1_tag_state_regs.sv
// Per-set valid bits (two ways) and a one-bit LRU pointer per set.
// The LRU bit names the way to evict next; flush_all wins over a same-cycle update.
module l1_tag_state_regs
   import l1_cache_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  idx_t       rd_idx,
   output logic [1:0] rd_valid,
   output logic       rd_lru,
   input  logic       upd_en,
   input  idx_t       upd_idx,
   input  logic       upd_way,
   input  logic       upd_set_valid,
   input  logic       upd_touch,
   input  logic       flush_all
);

   logic [NUM_SETS-1:0][1:0] valid_q, valid_d;
   logic [NUM_SETS-1:0]      lru_q, lru_d;

   assign rd_valid = valid_q[rd_idx];
   assign rd_lru   = lru_q[rd_idx];

   always_comb begin
      valid_d = valid_q;
      lru_d   = lru_q;
      if (flush_all) begin
         valid_d = '0;
         lru_d   = '0;
      end else if (upd_en) begin
         if (upd_set_valid) valid_d[upd_idx][upd_way] = 1'b1;
         if (upd_touch)     lru_d[upd_idx]            = ~upd_way;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         lru_q   <= '0;
      end else begin
         valid_q <= valid_d;
         lru_q   <= lru_d;
      end
   end

endmodule

// File: rtl/l1_tag_ctrl.sv
// 2-way L1 tag sequencer: lookup/compare, victim choice, refill tag write and one-cycle flush.
// Handshake: a request is taken on a rising edge where req_valid and req_ready are both 1.
module l1_tag_ctrl
   import l1_cache_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic               CK,
   input  logic               RSTn,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [31:0]        req_addr,
   output logic               resp_valid,
   output logic               resp_hit,
   output logic               resp_way,
   output logic               miss_req,
   input  logic               fill_done,
   input  logic               flush_req,
   output logic               flush_ack,
   output logic               TA_CS,
   output logic               TA_OE,
   output logic [1:0]         TA_WEB,
   output logic [IDX_W-1:0]   TA_A,
   output logic [TAG_W-1:0]   TA_DI,
   input  logic [2*TAG_W-1:0] TA_DO,
   output logic [CNT_W-1:0]   perf_hit_cnt,
   output logic [CNT_W-1:0]   perf_miss_cnt
);

   tag_state_e       state_q, state_d;
   tag_t             tag_q, tag_d;
   idx_t             idx_q, idx_d;
   logic             victim_q, victim_d;
   logic             flush_ack_q, flush_ack_d;
   logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
   logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

   logic [1:0] rd_valid;
   logic       rd_lru;
   logic       upd_en, upd_way, upd_set_valid, upd_touch, flush_all;

   tag_t req_tag;
   idx_t req_idx;
   logic unused_offset;
   logic hit0, hit1, any_hit, hit_way, victim;

   assign req_tag       = req_addr[OFF_W+IDX_W +: TAG_W];
   assign req_idx       = req_addr[OFF_W +: IDX_W];
   assign unused_offset = ^req_addr[OFF_W-1:0];

   // Way 0 wins a double hit; an empty way is always preferred as victim over LRU.
   assign hit0    = rd_valid[0] & (TA_DO[TAG_W-1:0] == tag_q);
   assign hit1    = rd_valid[1] & (TA_DO[2*TAG_W-1:TAG_W] == tag_q);
   assign any_hit = hit0 | hit1;
   assign hit_way = ~hit0;
   assign victim  = !rd_valid[0] ? 1'b0 : (!rd_valid[1] ? 1'b1 : rd_lru);

   assign req_ready     = (state_q == IDLE) && !flush_req;
   assign miss_req      = (state_q == MISS_WAIT);
   assign flush_ack     = flush_ack_q;
   assign TA_OE         = 1'b1;
   assign perf_hit_cnt  = hit_cnt_q;
   assign perf_miss_cnt = miss_cnt_q;

   l1_tag_state_regs u_state_regs (
      .clk           (CK),
      .rst_n         (RSTn),
      .rd_idx        (idx_q),
      .rd_valid      (rd_valid),
      .rd_lru        (rd_lru),
      .upd_en        (upd_en),
      .upd_idx       (idx_q),
      .upd_way       (upd_way),
      .upd_set_valid (upd_set_valid),
      .upd_touch     (upd_touch),
      .flush_all     (flush_all)
   );

   always_comb begin
      state_d       = state_q;
      tag_d         = tag_q;
      idx_d         = idx_q;
      victim_d      = victim_q;
      flush_ack_d   = 1'b0;
      hit_cnt_d     = hit_cnt_q;
      miss_cnt_d    = miss_cnt_q;
      upd_en        = 1'b0;
      upd_way       = 1'b0;
      upd_set_valid = 1'b0;
      upd_touch     = 1'b0;
      flush_all     = 1'b0;
      resp_valid    = 1'b0;
      resp_hit      = 1'b0;
      resp_way      = 1'b0;
      TA_CS         = 1'b0;
      TA_WEB        = 2'b11;
      TA_A          = '0;
      TA_DI         = '0;

      case (state_q)
         IDLE: begin
            if (flush_req) begin
               flush_all   = 1'b1;
               flush_ack_d = 1'b1;
            end else if (req_valid) begin
               tag_d   = req_tag;
               idx_d   = req_idx;
               TA_CS   = 1'b1;
               TA_A    = req_idx;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            resp_valid = 1'b1;
            if (any_hit) begin
               resp_hit  = 1'b1;
               resp_way  = hit_way;
               upd_en    = 1'b1;
               upd_way   = hit_way;
               upd_touch = 1'b1;
               if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
               state_d   = IDLE;
            end else begin
               resp_way  = victim;
               victim_d  = victim;
               if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
               state_d   = MISS_WAIT;
            end
         end
         MISS_WAIT: begin
            if (fill_done) state_d = FILL;
         end
         FILL: begin
            TA_CS         = 1'b1;
            TA_WEB        = victim_q ? 2'b01 : 2'b10;
            TA_A          = idx_q;
            TA_DI         = tag_q;
            upd_en        = 1'b1;
            upd_way       = victim_q;
            upd_set_valid = 1'b1;
            upd_touch     = 1'b1;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CK or negedge RSTn) begin
      if (!RSTn) begin
         state_q     <= IDLE;
         tag_q       <= '0;
         idx_q       <= '0;
         victim_q    <= 1'b0;
         flush_ack_q <= 1'b0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         tag_q       <= tag_d;
         idx_q       <= idx_d;
         victim_q    <= victim_d;
         flush_ack_q <= flush_ack_d;
         hit_cnt_q   <= hit_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
      end
   end

endmodule

// File: tb/tb_l1_tag_ctrl.sv
// Directed bench for l1_tag_ctrl with a behavioural tag SRAM (1-cycle read latency).
module tb_l1_tag_ctrl;

   logic        CK;
   logic        RSTn;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic        resp_hit;
   logic        resp_way;
   logic        miss_req;
   logic        fill_done;
   logic        flush_req;
   logic        flush_ack;
   logic        TA_CS;
   logic        TA_OE;
   logic [1:0]  TA_WEB;
   logic [4:0]  TA_A;
   logic [22:0] TA_DI;
   logic [45:0] TA_DO;
   logic [15:0] perf_hit_cnt;
   logic [15:0] perf_miss_cnt;

   int n_checks = 0;
   int n_errors = 0;

   l1_tag_ctrl dut (
      .CK            (CK),
      .RSTn          (RSTn),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .resp_valid    (resp_valid),
      .resp_hit      (resp_hit),
      .resp_way      (resp_way),
      .miss_req      (miss_req),
      .fill_done     (fill_done),
      .flush_req     (flush_req),
      .flush_ack     (flush_ack),
      .TA_CS         (TA_CS),
      .TA_OE         (TA_OE),
      .TA_WEB        (TA_WEB),
      .TA_A          (TA_A),
      .TA_DI         (TA_DI),
      .TA_DO         (TA_DO),
      .perf_hit_cnt  (perf_hit_cnt),
      .perf_miss_cnt (perf_miss_cnt)
   );

   // clock / reset
   initial begin
      CK = 1'b0;
      forever #5 CK = ~CK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached (errors=%0d of %0d checks)", n_errors, n_checks);
      $fatal(1, "watchdog");
   end

   // tag SRAM model
   logic [22:0] mem0 [0:31];
   logic [22:0] mem1 [0:31];

   always @(posedge CK) begin
      if (TA_CS) begin
         if (!TA_WEB[0]) mem0[TA_A] <= TA_DI;
         if (!TA_WEB[1]) mem1[TA_A] <= TA_DI;
         TA_DO <= {mem1[TA_A], mem0[TA_A]};
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic do_req(input logic [31:0] addr, input logic [4:0] exp_idx,
                         input logic exp_hit, input logic exp_way, input string nm);
      @(negedge CK);
      req_valid = 1'b1;
      req_addr  = addr;
      #1;
      check_eq({nm, "_ready"}, req_ready, 1);
      check_eq({nm, "_cs"},    TA_CS, 1);
      check_eq({nm, "_web"},   TA_WEB, 2'b11);
      check_eq({nm, "_a"},     TA_A, exp_idx);
      @(negedge CK);
      req_valid = 1'b0;
      #1;
      check_eq({nm, "_rvalid"}, resp_valid, 1);
      check_eq({nm, "_rhit"},   resp_hit, exp_hit);
      check_eq({nm, "_rway"},   resp_way, exp_way);
      check_eq({nm, "_lk_rdy"}, req_ready, 0);
   endtask

   task automatic do_fill(input logic [1:0] exp_web, input logic [4:0] exp_idx,
                          input logic [22:0] exp_tag, input string nm);
      @(negedge CK);
      #1;
      check_eq({nm, "_missreq"}, miss_req, 1);
      check_eq({nm, "_mw_rdy"},  req_ready, 0);
      check_eq({nm, "_mw_cs"},   TA_CS, 0);
      fill_done = 1'b1;
      @(negedge CK);
      fill_done = 1'b0;
      #1;
      check_eq({nm, "_fcs"},  TA_CS, 1);
      check_eq({nm, "_fweb"}, TA_WEB, exp_web);
      check_eq({nm, "_fa"},   TA_A, exp_idx);
      check_eq({nm, "_fdi"},  TA_DI, exp_tag);
      check_eq({nm, "_fmr"},  miss_req, 0);
   endtask

   task automatic idle_cnt(input logic [15:0] exp_hits, input logic [15:0] exp_miss, input string nm);
      @(negedge CK);
      #1;
      check_eq({nm, "_idle_rdy"}, req_ready, 1);
      check_eq({nm, "_idle_cs"},  TA_CS, 0);
      check_eq({nm, "_hitcnt"},   perf_hit_cnt, exp_hits);
      check_eq({nm, "_misscnt"},  perf_miss_cnt, exp_miss);
   endtask

   task automatic check_reset_vals(input string nm);
      check_eq({nm, "_ready"},   req_ready, 1);
      check_eq({nm, "_rvalid"},  resp_valid, 0);
      check_eq({nm, "_missreq"}, miss_req, 0);
      check_eq({nm, "_fack"},    flush_ack, 0);
      check_eq({nm, "_cs"},      TA_CS, 0);
      check_eq({nm, "_oe"},      TA_OE, 1);
      check_eq({nm, "_web"},     TA_WEB, 2'b11);
      check_eq({nm, "_a"},       TA_A, 0);
      check_eq({nm, "_di"},      TA_DI, 0);
      check_eq({nm, "_hitcnt"},  perf_hit_cnt, 0);
      check_eq({nm, "_misscnt"}, perf_miss_cnt, 0);
   endtask

   initial begin
      RSTn      = 1'b0;
      req_valid = 1'b0;
      req_addr  = 32'h0;
      fill_done = 1'b0;
      flush_req = 1'b0;
      #1;
      check_reset_vals("rst");
      repeat (2) @(negedge CK);
      RSTn = 1'b1;

      // 1: cold miss then hit
      do_req(32'h0000_1230, 5'h03, 1'b0, 1'b0, "t1_miss");
      do_fill(2'b10, 5'h03, 23'h000009, "t1_fill");
      do_req(32'h0000_1230, 5'h03, 1'b1, 1'b0, "t1_hit");
      idle_cnt(16'd1, 16'd1, "t1");

      // 2: second way, LRU victim
      do_req(32'h0000_2230, 5'h03, 1'b0, 1'b1, "t2_miss2");
      do_fill(2'b01, 5'h03, 23'h000011, "t2_fill2");
      do_req(32'h0000_1230, 5'h03, 1'b1, 1'b0, "t2_hit1");
      do_req(32'h0000_3230, 5'h03, 1'b0, 1'b1, "t2_miss3");
      do_fill(2'b01, 5'h03, 23'h000019, "t2_fill3");
      do_req(32'h0000_1230, 5'h03, 1'b1, 1'b0, "t2_hit1b");
      do_req(32'h0000_2230, 5'h03, 1'b0, 1'b1, "t2_miss2b");
      do_fill(2'b01, 5'h03, 23'h000011, "t2_fill2b");
      do_req(32'h0000_2230, 5'h03, 1'b1, 1'b1, "t2_hit2");
      idle_cnt(16'd4, 16'd4, "t2");

      // 3: flush beats a simultaneous request in IDLE
      @(negedge CK);
      flush_req = 1'b1;
      req_valid = 1'b1;
      req_addr  = 32'h0000_1230;
      #1;
      check_eq("t3_rdy_flush", req_ready, 0);
      check_eq("t3_cs_flush",  TA_CS, 0);
      check_eq("t3_ack_early", flush_ack, 0);
      @(negedge CK);
      flush_req = 1'b0;
      #1;
      check_eq("t3_ack",     flush_ack, 1);
      check_eq("t3_rdy",     req_ready, 1);
      check_eq("t3_cs",      TA_CS, 1);
      check_eq("t3_hitcnt",  perf_hit_cnt, 16'd4);
      @(negedge CK);
      req_valid = 1'b0;
      #1;
      check_eq("t3_rvalid",  resp_valid, 1);
      check_eq("t3_rhit",    resp_hit, 0);
      check_eq("t3_rway",    resp_way, 0);
      check_eq("t3_ack_off", flush_ack, 0);
      do_fill(2'b10, 5'h03, 23'h000009, "t3_fill");

      // 4: flush and request held during MISS_WAIT
      do_req(32'h0000_5670, 5'h07, 1'b0, 1'b0, "t4_miss");
      @(negedge CK);
      flush_req = 1'b1;
      req_valid = 1'b1;
      req_addr  = 32'h0000_5670;
      #1;
      check_eq("t4_mw_rdy", req_ready, 0);
      check_eq("t4_mw_mr",  miss_req, 1);
      check_eq("t4_mw_cs",  TA_CS, 0);
      @(negedge CK);
      #1;
      check_eq("t4_mw_ack", flush_ack, 0);
      fill_done = 1'b1;
      @(negedge CK);
      fill_done = 1'b0;
      #1;
      check_eq("t4_fweb",    TA_WEB, 2'b10);
      check_eq("t4_fa",      TA_A, 5'h07);
      check_eq("t4_fdi",     TA_DI, 23'h00002B);
      check_eq("t4_fill_ack", flush_ack, 0);
      check_eq("t4_fill_rdy", req_ready, 0);
      @(negedge CK);
      #1;
      check_eq("t4_idle_ack", flush_ack, 0);
      check_eq("t4_idle_rdy", req_ready, 0);
      check_eq("t4_idle_cs",  TA_CS, 0);
      @(negedge CK);
      flush_req = 1'b0;
      #1;
      check_eq("t4_ack", flush_ack, 1);
      check_eq("t4_rdy", req_ready, 1);
      check_eq("t4_cs",  TA_CS, 1);
      check_eq("t4_a",   TA_A, 5'h07);
      @(negedge CK);
      req_valid = 1'b0;
      #1;
      check_eq("t4_rvalid", resp_valid, 1);
      check_eq("t4_rhit",   resp_hit, 0);
      check_eq("t4_rway",   resp_way, 0);
      do_fill(2'b10, 5'h07, 23'h00002B, "t4_fill");
      idle_cnt(16'd4, 16'd7, "t4");

      // 5: async reset while waiting for a fill
      do_req(32'h0000_1230, 5'h03, 1'b0, 1'b0, "t5_miss");
      @(negedge CK);
      #1;
      check_eq("t5_mw_mr",  miss_req, 1);
      check_eq("t5_mw_cnt", perf_miss_cnt, 16'd8);
      RSTn = 1'b0;
      #1;
      check_reset_vals("t5_rst");
      repeat (2) @(negedge CK);
      RSTn = 1'b1;
      @(negedge CK);
      fill_done = 1'b1;
      #1;
      check_eq("t5_fd_web", TA_WEB, 2'b11);
      @(negedge CK);
      fill_done = 1'b0;
      #1;
      check_eq("t5_post_web", TA_WEB, 2'b11);
      check_eq("t5_post_cs",  TA_CS, 0);
      check_eq("t5_post_mr",  miss_req, 0);
      do_req(32'h0000_1230, 5'h03, 1'b0, 1'b0, "t5_miss2");
      do_fill(2'b10, 5'h03, 23'h000009, "t5_fill");
      do_req(32'h0000_1230, 5'h03, 1'b1, 1'b0, "t5_hit");
      idle_cnt(16'd1, 16'd1, "t5");

      // 6: hit counter saturation
      @(negedge CK);
      force dut.hit_cnt_q = 16'hFFFE;
      @(negedge CK);
      release dut.hit_cnt_q;
      #1;
      check_eq("t6_preset", perf_hit_cnt, 16'hFFFE);
      do_req(32'h0000_1230, 5'h03, 1'b1, 1'b0, "t6_h1");
      idle_cnt(16'hFFFF, 16'd1, "t6_1");
      do_req(32'h0000_1230, 5'h03, 1'b1, 1'b0, "t6_h2");
      idle_cnt(16'hFFFF, 16'd1, "t6_2");
      do_req(32'h0000_1230, 5'h03, 1'b1, 1'b0, "t6_h3");
      idle_cnt(16'hFFFF, 16'd1, "t6_3");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
